// File: rtl/alu_issue_unit.sv
// Sequencer for an external combinational 8-bit ALU: accepts one instruction at a time,
// reads operands from an 8x8 register file, executes, and writes results and status back.
module alu_issue_unit #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_load,
  input  logic [3:0]        instr_op,
  input  logic [2:0]        instr_rd,
  input  logic [2:0]        instr_ra,
  input  logic [2:0]        instr_rb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_fsl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_mul_high,
  input  logic [3:0]        alu_sreg,
  output logic [3:0]        sreg,
  output logic              done,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, WB_HI} state_e;

  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_CMP = 4'b1111;

  typedef struct packed {
    logic              load;
    logic [2:0]        rd;
    logic [DATA_W-1:0] imm;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] hi;
    logic [3:0]        sr;
  } rsp_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  rsp_t              rsp_q, rsp_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_fsl_q, alu_fsl_d;
  logic [3:0]        sreg_q, sreg_d;
  logic              done_q, done_d;
  logic [2:0]        rd_inc;

  assign rd_inc = req_q.rd + 3'd1;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rsp_d     = rsp_q;
    rf_d      = rf_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fsl_d = alu_fsl_q;
    sreg_d    = sreg_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          req_d.load = instr_load;
          req_d.rd   = instr_rd;
          if (instr_load) begin
            req_d.imm = instr_imm;
            state_d   = WB;
            done_d    = 1'b1;
          end else begin
            alu_a_d   = rf_q[instr_ra];
            alu_b_d   = rf_q[instr_rb];
            alu_fsl_d = instr_op;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        rsp_d   = '{res: alu_result, hi: alu_mul_high, sr: alu_sreg};
        state_d = WB;
        // done is registered, so raise it on entry to the retiring state
        done_d  = (alu_fsl_q != OP_MUL);
      end
      WB: begin
        if (req_q.load) begin
          rf_d[req_q.rd] = req_q.imm;
        end else begin
          if (alu_fsl_q != OP_CMP) rf_d[req_q.rd] = rsp_q.res;
          sreg_d = rsp_q.sr;
        end
        if (!req_q.load && alu_fsl_q == OP_MUL) begin
          state_d = WB_HI;
          done_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WB_HI: begin
        rf_d[rd_inc] = rsp_q.hi;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fsl_q <= '0;
      sreg_q    <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rsp_q     <= rsp_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fsl_q <= alu_fsl_d;
      sreg_q    <= sreg_d;
      done_q    <= done_d;
      rf_q      <= rf_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_fsl     = alu_fsl_q;
  assign sreg        = sreg_q;
  assign done        = done_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU, reference register file and a retire scoreboard.
module tb_alu_issue_unit;

  logic       clk, rst_n;
  logic       instr_valid, instr_ready, instr_load;
  logic [3:0] instr_op;
  logic [2:0] instr_rd, instr_ra, instr_rb;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b, alu_result, alu_mul_high;
  logic [3:0] alu_fsl, alu_sreg, sreg;
  logic       done;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_CMP = 4'b1111;

  typedef struct {
    logic       load;
    logic [3:0] op;
    logic [2:0] rd;
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] sr;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mrf [8];
  logic [3:0] msreg;

  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_load(instr_load),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fsl(alu_fsl),
    .alu_result(alu_result), .alu_mul_high(alu_mul_high), .alu_sreg(alu_sreg),
    .sreg(sreg), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU, returns {mul_high, result, {V,S,C,Z}}
  function automatic logic [19:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r, h;
    logic        v, c;
    h = 8'h00;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_MUL: begin
        p = a * b; r = p[7:0]; h = p[15:8]; c = p[15]; v = 1'b0;
      end
      OP_CMP: begin
        s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      default: begin
        r = a ^ b; c = 1'b0; v = 1'b0;
      end
    endcase
    return {h, r, v, r[7], c, (op == OP_MUL) ? (p == 16'h0) : (r == 8'h00)};
  endfunction

  always_comb {alu_mul_high, alu_result, alu_sreg} = alu_f(alu_a, alu_b, alu_fsl);

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (instr_ready) begin
        failures++;
        $display("FAIL done_ready_overlap: instr_ready=%0b while done=1, required 0", instr_ready);
      end
    end
  end

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== mrf[i]) begin
        failures++;
        $display("FAIL %s_r%0d: got %02h required %02h", tag, i, dbg_data, mrf[i]);
      end
    end
    checks++;
    if (sreg !== msreg) begin
      failures++;
      $display("FAIL %s_sreg: got %04b required %04b", tag, sreg, msreg);
    end
  endtask

  function automatic exp_t make_exp(input logic ld, input logic [3:0] op, input logic [2:0] rd,
                                    input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm);
    exp_t e;
    logic [19:0] a;
    a = alu_f(mrf[ra], mrf[rb], op);
    e.load = ld; e.op = op; e.rd = rd;
    e.res = ld ? imm : a[11:4];
    e.hi  = a[19:12];
    e.sr  = ld ? msreg : a[3:0];
    e.lat = ld ? 1 : (op == OP_MUL) ? 3 : 2;
    return e;
  endfunction

  task automatic retire(input exp_t e);
    if (e.load) mrf[e.rd] = e.res;
    else begin
      if (e.op != OP_CMP) mrf[e.rd] = e.res;
      msreg = e.sr;
      if (e.op == OP_MUL) mrf[3'(e.rd + 3'd1)] = e.hi;
    end
  endtask

  task automatic issue(input string tag, input logic ld, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm);
    int   lat, w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (!instr_ready) begin
      failures++;
      $display("FAIL %s_ready_timeout: instr_ready=%0b required 1", tag, instr_ready);
      return;
    end
    instr_valid = 1'b1; instr_load = ld; instr_op = op;
    instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
    sb.push_back(make_exp(ld, op, rd, ra, rb, imm));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 10);
    e = sb.pop_front();
    checks++;
    if (!done || lat != e.lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles (done=%0b) required %0d", tag, lat, done, e.lat);
    end
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_post_retire: ready=%0b done=%0b required ready=1 done=0", tag, instr_ready, done);
    end
    retire(e);
    check_regs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
    msreg = 4'h0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%0b done=%0b required ready=1 done=0", instr_ready, done);
    end
    checks++;
    if ({alu_a, alu_b, alu_fsl} !== 20'h0) begin
      failures++;
      $display("FAIL reset_alu_in: got %02h %02h %01h required 00 00 0", alu_a, alu_b, alu_fsl);
    end
    check_regs("reset");
  endtask

  task automatic test_add_overflow();
    issue("ld_r1", 1'b1, 4'h0, 3'd1, 3'd0, 3'd0, 8'h7F);
    issue("ld_r2", 1'b1, 4'h0, 3'd2, 3'd0, 3'd0, 8'h01);
    issue("add", 1'b0, OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    dbg_addr = 3'd3; #1;
    checks++;
    if (dbg_data !== 8'h80 || sreg !== 4'b1100) begin
      failures++;
      $display("FAIL add_const: r3=%02h sreg=%04b required r3=80 sreg=1100", dbg_data, sreg);
    end
  endtask

  task automatic test_multiply_wrap();
    issue("ld_r1b", 1'b1, 4'h0, 3'd1, 3'd0, 3'd0, 8'h10);
    issue("ld_r2b", 1'b1, 4'h0, 3'd2, 3'd0, 3'd0, 8'h10);
    issue("mul", 1'b0, OP_MUL, 3'd7, 3'd1, 3'd2, 8'h00);
    dbg_addr = 3'd7; #1;
    checks++;
    if (dbg_data !== 8'h00) begin
      failures++;
      $display("FAIL mul_r7: got %02h required 00", dbg_data);
    end
    dbg_addr = 3'd0; #1;
    checks++;
    if (dbg_data !== 8'h01) begin
      failures++;
      $display("FAIL mul_r0_wrap: got %02h required 01", dbg_data);
    end
  endtask

  task automatic test_compare();
    issue("cmp", 1'b0, OP_CMP, 3'd4, 3'd1, 3'd1, 8'h00);
    checks++;
    if (sreg[0] !== 1'b1) begin
      failures++;
      $display("FAIL cmp_z: got %0b required 1", sreg[0]);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc, acc, dn;
    int   acc_cyc [2];
    exp_t e;
    cyc = 0; acc = 0; dn = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr_load = 1'b1; instr_rd = 3'd4; instr_imm = 8'hAA;
    repeat (12) begin
      if (done) dn++;
      if (instr_ready && instr_valid) begin
        if (acc < 2) acc_cyc[acc] = cyc;
        acc++;
        sb.push_back(make_exp(1'b1, 4'h0, instr_rd, 3'd0, 3'd0, instr_imm));
      end else if (acc == 1) begin
        instr_rd = 3'd5; instr_imm = 8'h55;
      end else if (acc == 2) begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0;
    checks++;
    if (acc != 2 || dn != 2) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d dones=%0d required 2 and 2", acc, dn);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] != 2) begin
      failures++;
      $display("FAIL b2b_gap: got %0d cycles required 2", acc_cyc[1] - acc_cyc[0]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      retire(e);
    end
    check_regs("b2b");
  endtask

  task automatic test_reset_in_exec();
    int dn;
    issue("ld_r6", 1'b1, 4'h0, 3'd6, 3'd0, 3'd0, 8'h33);
    @(negedge clk);
    instr_valid = 1'b1; instr_load = 1'b0; instr_op = OP_ADD;
    instr_rd = 3'd6; instr_ra = 3'd6; instr_rb = 3'd6;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n = 1'b0;
    dn = 0;
    repeat (3) begin @(negedge clk); if (done) dn++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) dn++; end
    for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
    msreg = 4'h0;
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL rst_exec_done: got %0d pulses required 0", dn);
    end
    check_regs("rst_exec");
    issue("post_ld", 1'b1, 4'h0, 3'd6, 3'd0, 3'd0, 8'h05);
    issue("post_add", 1'b0, OP_ADD, 3'd2, 3'd6, 3'd6, 8'h00);
  endtask

  initial begin
    instr_valid = 1'b0; instr_load = 1'b0; instr_op = 4'h0;
    instr_rd = 3'd0; instr_ra = 3'd0; instr_rb = 3'd0; instr_imm = 8'h00;
    dbg_addr = 3'd0;
    test_reset();
    test_add_overflow();
    test_multiply_wrap();
    test_compare();
    test_back_to_back();
    test_reset_in_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
